cohort_tri_bridge: RTL



---
 rtl/cohort_tri_bridge.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/cohort_tri_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cohort_tri_bridge (with cohort_tri_pkg)
// Description : Single-outstanding bridge from a Cohort engine memory client
//               port (valid/ready load/store/atomic) to the L1.5 TRI port.
//               Issues one tri_req_t at a time and holds it until req_ack.
//               Matches the returning tri_resp_t and hands data back to the
//               client. Also absorbs EVICT / invalidation traffic.
// Ports       : clk, rst_n         - clock, async active-low reset
//               cli_req_*          - client request channel (valid/ready)
//               cli_rsp_*          - client response channel (valid/ready)
//               tri_req_o          - request to L1.5 (carries resp_ack)
//               tri_resp_i         - response from L1.5 (carries req_ack)
//               inv_valid_o/addr_o - one-cycle invalidation notice
//               err_unexp          - sticky: unexpected response in WAIT
//               err_timeout        - sticky: WAIT reached TIMEOUT_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================

package cohort_tri_pkg;
    localparam logic [4:0] TRI_LOAD_RQ                = 5'b00000;
    localparam logic [4:0] TRI_STORE_RQ               = 5'b00001;
    localparam logic [4:0] TRI_ATOMIC_RQ              = 5'b00110;

    localparam logic [3:0] TRI_LOAD_RET               = 4'b0000;
    localparam logic [3:0] TRI_EVICT_REQ              = 4'b0011;
    localparam logic [3:0] TRI_ST_ACK                 = 4'b0100;
    localparam logic [3:0] TRI_INT_RET                = 4'b0111;
    localparam logic [3:0] TRI_CPX_RESTYPE_ATOMIC_RES = 4'b1110;

    typedef struct packed {
        logic         req_valid;
        logic [4:0]   req_type;
        logic [3:0]   req_amo_op;
        logic [2:0]   req_size;
        logic [39:0]  req_addr;
        logic [127:0] req_data;
        logic         resp_ack;
    } tri_req_t;

    typedef struct packed {
        logic         req_ack;
        logic         resp_val;
        logic [3:0]   resp_type;
        logic         resp_atomic;
        logic [127:0] resp_data;
        logic         resp_inv_valid;
        logic [11:0]  resp_inv_addr;
    } tri_resp_t;
endpackage

module cohort_tri_bridge
    import cohort_tri_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cli_req_valid,
    output logic          cli_req_ready,
    input  logic [1:0]    cli_req_op,
    input  logic [3:0]    cli_req_amo_op,
    input  logic [2:0]    cli_req_size,
    input  logic [39:0]   cli_req_addr,
    input  logic [127:0]  cli_req_data,
    output logic          cli_rsp_valid,
    input  logic          cli_rsp_ready,
    output logic [127:0]  cli_rsp_data,
    output tri_req_t      tri_req_o,
    input  tri_resp_t     tri_resp_i,
    output logic          inv_valid_o,
    output logic [11:0]   inv_addr_o,
    output logic          err_unexp,
    output logic          err_timeout
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_TMO = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic             r_req_valid;
    logic [4:0]       r_type;
    logic [3:0]       r_amo_op;
    logic [2:0]       r_size;
    logic [39:0]      r_addr;
    logic [127:0]     r_data;
    logic             r_rsp_valid;
    logic [127:0]     r_rsp_data;
    logic             r_inv_valid;
    logic [11:0]      r_inv_addr;
    logic             r_err_unexp;
    logic             r_err_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_is_evict;
    logic             w_expected;
    logic             w_rsp_hit;
    logic             w_resp_ack;
    logic             w_inv_hit;
    logic             w_tmo_hit;
    logic [4:0]       w_map_type;
    logic [CNT_W-1:0] w_cnt_inc;

    // Reserved op 3 maps to a load.
    always_comb begin
        w_map_type = TRI_LOAD_RQ;
        case (cli_req_op)
            2'd1:    w_map_type = TRI_STORE_RQ;
            2'd2:    w_map_type = TRI_ATOMIC_RQ;
            default: w_map_type = TRI_LOAD_RQ;
        endcase
    end

    // Atomics may complete either with a dedicated atomic result or with a
    // load return flagged as atomic.
    always_comb begin
        w_expected = 1'b0;
        case (r_op)
            2'd1:    w_expected = (tri_resp_i.resp_type == TRI_ST_ACK);
            2'd2:    w_expected = (tri_resp_i.resp_type == TRI_CPX_RESTYPE_ATOMIC_RES) ||
                                  ((tri_resp_i.resp_type == TRI_LOAD_RET) && tri_resp_i.resp_atomic);
            default: w_expected = (tri_resp_i.resp_type == TRI_LOAD_RET);
        endcase
    end

    assign w_is_evict = (tri_resp_i.resp_type == TRI_EVICT_REQ);
    assign w_rsp_hit  = (r_state == c_WAIT) && tri_resp_i.resp_val && w_expected;

    // EVICT is always taken; everything else only while waiting. Gated by
    // rst_n so an in-flight response is never acked while in reset.
    assign w_resp_ack = rst_n && tri_resp_i.resp_val && (w_is_evict || (r_state == c_WAIT));
    assign w_inv_hit  = w_resp_ack && (tri_resp_i.resp_inv_valid || w_is_evict);

    // Flag fires on the edge where the counter reaches the threshold, so the
    // error is visible right after the TIMEOUT_CYCLES-th WAIT cycle.
    assign w_cnt_inc  = r_cnt + c_ONE;
    assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && (r_cnt != '1) && (w_cnt_inc == c_TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_op          <= 2'd0;
            r_req_valid   <= 1'b0;
            r_type        <= 5'd0;
            r_amo_op      <= 4'd0;
            r_size        <= 3'd0;
            r_addr        <= 40'd0;
            r_data        <= 128'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 128'd0;
            r_inv_valid   <= 1'b0;
            r_inv_addr    <= 12'd0;
            r_err_unexp   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_inv_valid <= w_inv_hit;
            if (w_inv_hit) begin
                r_inv_addr <= tri_resp_i.resp_inv_addr;
            end

            case (r_state)
                c_IDLE: begin
                    if (cli_req_valid) begin
                        r_op        <= cli_req_op;
                        r_type      <= w_map_type;
                        r_amo_op    <= cli_req_amo_op;
                        r_size      <= cli_req_size;
                        r_addr      <= cli_req_addr;
                        r_data      <= cli_req_data;
                        r_req_valid <= 1'b1;
                        r_state     <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (tri_resp_i.req_ack) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt != '1) begin
                        r_cnt <= w_cnt_inc;
                    end
                    if (w_tmo_hit) begin
                        r_err_timeout <= 1'b1;
                    end
                    if (w_rsp_hit) begin
                        r_rsp_data  <= tri_resp_i.resp_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else if (tri_resp_i.resp_val && !w_is_evict) begin
                        r_err_unexp <= 1'b1;
                    end
                end
                c_DONE: begin
                    if (cli_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        tri_req_o            = '0;
        tri_req_o.req_valid  = r_req_valid;
        tri_req_o.req_type   = r_type;
        tri_req_o.req_amo_op = r_amo_op;
        tri_req_o.req_size   = r_size;
        tri_req_o.req_addr   = r_addr;
        tri_req_o.req_data   = r_data;
        tri_req_o.resp_ack   = w_resp_ack;
    end

    assign cli_req_ready = (r_state == c_IDLE);
    assign cli_rsp_valid = r_rsp_valid;
    assign cli_rsp_data  = r_rsp_data;
    assign inv_valid_o   = r_inv_valid;
    assign inv_addr_o    = r_inv_addr;
    assign err_unexp     = r_err_unexp;
    assign err_timeout   = r_err_timeout;

endmodule
`default_nettype wire
